// File: rtl/zbus_pkg.sv
// zbus_pkg: shared types and constants for the Z80-style bus initiator.
// Holds the cycle state enum, cycle-type codes, the command payload struct
// and the default CPLD port addresses used by test sequencers.
package zbus_pkg;

    localparam int unsigned ZB_AW = 16;
    localparam int unsigned ZB_DW = 8;

    typedef enum logic [2:0] {
        ZB_IDLE,
        ZB_T1,
        ZB_T2,
        ZB_TW,
        ZB_T3,
        ZB_TH
    } zb_state_e;

    // Cycle type encoded as {io, wr}
    typedef logic [1:0] zb_cyc_t;
    localparam zb_cyc_t ZB_MEMRD = 2'b00;
    localparam zb_cyc_t ZB_MEMWR = 2'b01;
    localparam zb_cyc_t ZB_IORD  = 2'b10;
    localparam zb_cyc_t ZB_IOWR  = 2'b11;

    localparam logic [ZB_AW-1:0] ZB_PORT_83AB = 16'h83AB;
    localparam logic [ZB_AW-1:0] ZB_PORT_82AB = 16'h82AB;
    localparam logic [ZB_AW-1:0] ZB_PORT_81AB = 16'h81AB;
    localparam logic [ZB_AW-1:0] ZB_PORT_80AB = 16'h80AB;
    localparam logic [ZB_AW-1:0] ZB_PORT_7FAB = 16'h7FAB;

    typedef struct packed {
        logic             io;
        logic             wr;
        logic [ZB_AW-1:0] addr;
        logic [ZB_DW-1:0] wdata;
    } zb_cmd_t;

    function automatic zb_cyc_t zb_cyc_type(input zb_cmd_t c);
        return {c.io, c.wr};
    endfunction

endpackage

// File: rtl/zbus_wait_ctr.sv
// zbus_wait_ctr: loadable down-counter with a terminal (zero) flag.
// Ports: clk, rst (sync, active-high), load/load_val (load has priority),
//        dec (decrement, saturates at zero), zero_c (count == 0, combinational).
module zbus_wait_ctr #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero_c
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins, otherwise decrement without wrapping
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/zbus_initiator.sv
// zbus_initiator: Z80-style bus master. Turns a valid/ready command into a
// memory or I/O read/write cycle (T1, T2, TWxN, T3, TH), one T-state per clk.
// Ports: clk, rst (sync, active-high); cmd_* command handshake; rsp_* one-cycle
//        completion pulse with read data and timeout error; za/zd_out/zd_oe/
//        zd_in data and address bus; zmreq_n/ziorq_n/zrd_n/zwr_n strobes;
//        zwait_n target wait request.
// Build option: ZBUS_INITIATOR_ZWAIT_EN enables zwait_n-driven extra waits
//        with a WAIT_TIMEOUT cap; otherwise zwait_n is ignored.
module zbus_initiator
    import zbus_pkg::*;
#(
    parameter int unsigned IO_WAIT      = 1,
    parameter int unsigned MEM_WAIT     = 0,
    parameter int unsigned WAIT_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_wr,
    input  logic             cmd_io,
    input  logic [ZB_AW-1:0] cmd_addr,
    input  logic [ZB_DW-1:0] cmd_wdata,
    output logic             rsp_valid,
    output logic [ZB_DW-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic [ZB_AW-1:0] za,
    output logic [ZB_DW-1:0] zd_out,
    output logic             zd_oe,
    input  logic [ZB_DW-1:0] zd_in,
    output logic             zmreq_n,
    output logic             ziorq_n,
    output logic             zrd_n,
    output logic             zwr_n,
    input  logic             zwait_n
);

    zb_state_e        state_q, state_d;
    zb_cmd_t          cmd_q, cmd_d;
    logic             err_q, err_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [ZB_DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic             rsp_err_q, rsp_err_d;
    logic [ZB_AW-1:0] za_q, za_d;
    logic [ZB_DW-1:0] zd_out_q, zd_out_d;
    logic             zd_oe_q, zd_oe_d;
    logic             zmreq_n_q, zmreq_n_d;
    logic             ziorq_n_q, ziorq_n_d;
    logic             zrd_n_q, zrd_n_d;
    logic             zwr_n_q, zwr_n_d;

    logic             accept;
    logic             wait_load, wait_dec, wait_zero_c;
    logic             tmo_load, tmo_dec, tmo_zero_c;
    logic [1:0]       fixed_waits;

    assign fixed_waits = cmd_q.io ? 2'(IO_WAIT) : 2'(MEM_WAIT);

    // Fixed TW count for the current cycle
    zbus_wait_ctr #(.W(2)) u_fixed_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (wait_load),
        .load_val (fixed_waits),
        .dec      (wait_dec),
        .zero_c   (wait_zero_c)
    );

    // Budget of extra zwait_n-requested TW cycles
    zbus_wait_ctr #(.W(8)) u_tmo_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (tmo_load),
        .load_val (8'(WAIT_TIMEOUT)),
        .dec      (tmo_dec),
        .zero_c   (tmo_zero_c)
    );

`ifndef ZBUS_INITIATOR_ZWAIT_EN
    logic unused_c;
    assign unused_c = ^{zwait_n, tmo_zero_c};
`endif

    // Next state plus registered bus/response outputs derived from it
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        err_d       = err_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        wait_load   = 1'b0;
        wait_dec    = 1'b0;
        tmo_load    = 1'b0;
        tmo_dec     = 1'b0;
        zmreq_n_d   = 1'b1;
        ziorq_n_d   = 1'b1;
        zrd_n_d     = 1'b1;
        zwr_n_d     = 1'b1;
        accept      = cmd_valid & cmd_ready_q;

        unique case (state_q)
            ZB_IDLE: begin
                if (accept) begin
                    state_d = ZB_T1;
                end
            end
            ZB_T1: begin
                wait_load = 1'b1;
                tmo_load  = 1'b1;
                state_d   = ZB_T2;
            end
            ZB_T2, ZB_TW: begin
                if (!wait_zero_c) begin
                    wait_dec = 1'b1;
                    state_d  = ZB_TW;
`ifdef ZBUS_INITIATOR_ZWAIT_EN
                end else if (!zwait_n && !tmo_zero_c) begin
                    tmo_dec = 1'b1;
                    state_d = ZB_TW;
                end else begin
                    // Still held low with no budget left: give up with an error
                    err_d   = !zwait_n;
                    state_d = ZB_T3;
                end
`else
                end else begin
                    state_d = ZB_T3;
                end
`endif
            end
            ZB_T3: begin
                state_d     = ZB_TH;
                rsp_valid_d = 1'b1;
                rsp_err_d   = err_q;
                rsp_rdata_d = err_q ? 8'hFF : (cmd_q.wr ? 8'h00 : zd_in);
            end
            ZB_TH: begin
                state_d = accept ? ZB_T1 : ZB_IDLE;
            end
            default: begin
                state_d = ZB_IDLE;
            end
        endcase

        if (accept) begin
            cmd_d = '{io: cmd_io, wr: cmd_wr, addr: cmd_addr, wdata: cmd_wdata};
            err_d = 1'b0;
        end

        // Address and write data are launched in T1 and then held
        za_d        = (state_d == ZB_T1) ? cmd_d.addr : za_q;
        zd_out_d    = ((state_d == ZB_T1) && cmd_d.wr) ? cmd_d.wdata : zd_out_q;
        zd_oe_d     = (state_d != ZB_IDLE) && cmd_d.wr;
        cmd_ready_d = (state_d == ZB_IDLE) || (state_d == ZB_TH);

        // Exactly one space strobe and one direction strobe, T2 through T3
        if (state_d inside {ZB_T2, ZB_TW, ZB_T3}) begin
            unique case (zb_cyc_type(cmd_d))
                ZB_MEMRD: begin zmreq_n_d = 1'b0; zrd_n_d = 1'b0; end
                ZB_MEMWR: begin zmreq_n_d = 1'b0; zwr_n_d = 1'b0; end
                ZB_IORD:  begin ziorq_n_d = 1'b0; zrd_n_d = 1'b0; end
                ZB_IOWR:  begin ziorq_n_d = 1'b0; zwr_n_d = 1'b0; end
                default:  begin zmreq_n_d = 1'b1; end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ZB_IDLE;
            cmd_q       <= '0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            za_q        <= '0;
            zd_out_q    <= '0;
            zd_oe_q     <= 1'b0;
            zmreq_n_q   <= 1'b1;
            ziorq_n_q   <= 1'b1;
            zrd_n_q     <= 1'b1;
            zwr_n_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            err_q       <= err_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            za_q        <= za_d;
            zd_out_q    <= zd_out_d;
            zd_oe_q     <= zd_oe_d;
            zmreq_n_q   <= zmreq_n_d;
            ziorq_n_q   <= ziorq_n_d;
            zrd_n_q     <= zrd_n_d;
            zwr_n_q     <= zwr_n_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign za        = za_q;
    assign zd_out    = zd_out_q;
    assign zd_oe     = zd_oe_q;
    assign zmreq_n   = zmreq_n_q;
    assign ziorq_n   = ziorq_n_q;
    assign zrd_n     = zrd_n_q;
    assign zwr_n     = zwr_n_q;

endmodule

// File: tb/tb_zbus_initiator.sv
// tb_zbus_initiator: self-checking bench for zbus_initiator. A timeline model
// (accept cycle, T3 cycle, extra waits) predicts every output each cycle.
module tb_zbus_initiator;
    import zbus_pkg::*;

    localparam int unsigned IO_W  = 1;
    localparam int unsigned MEM_W = 0;
    localparam int unsigned TMO   = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_wr = 1'b0;
    logic        cmd_io = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [7:0]  cmd_wdata = '0;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic [15:0] za;
    logic [7:0]  zd_out;
    logic        zd_oe;
    logic [7:0]  zd_in = '0;
    logic        zmreq_n, ziorq_n, zrd_n, zwr_n;
    logic        zwait_n = 1'b1;

    always #5 clk = ~clk;

    zbus_initiator #(.IO_WAIT(IO_W), .MEM_WAIT(MEM_W), .WAIT_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_io(cmd_io),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .za(za), .zd_out(zd_out), .zd_oe(zd_oe), .zd_in(zd_in),
        .zmreq_n(zmreq_n), .ziorq_n(ziorq_n), .zrd_n(zrd_n), .zwr_n(zwr_n),
        .zwait_n(zwait_n)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    // Stimulus requested for the next cycle
    logic        drv_rst = 1'b1, drv_valid = 1'b0, drv_wr = 1'b0, drv_io = 1'b0;
    logic [15:0] drv_addr = '0;
    logic [7:0]  drv_wd = '0;
    int          zw_from = -1, zw_to = -1;
    bit          zw_rand = 1'b0;

    // Reference timeline
    bit          m_rst_prev = 1'b1;
    bit          m_act = 1'b0, m_wr = 1'b0, m_io = 1'b0, m_err = 1'b0;
    int          m_acc = 0, m_t3 = 0, m_extra = 0;
    logic [15:0] m_addr = '0, m_last_za = '0;
    logic [7:0]  m_wd = '0, m_rd = '0;

    // Observations of the DUT for directed checks
    bit          acc_flag;
    int          low_cnt = 0, rsp_cnt = 0, last_rsp_cyc = -1;
    logic        last_err = 1'b0;
    logic [7:0]  last_rd = '0;

    // One cycle: check outputs, apply inputs, advance the model
    task automatic tick();
        logic [6:0] eb, ob;
        bit         t1, low, th, busy, rdy;
        logic [7:0] zi;
        logic       zw;
        @(negedge clk);
        ob = {zmreq_n, ziorq_n, zrd_n, zwr_n, zd_oe, cmd_ready, rsp_valid};
        if (m_rst_prev) begin
            rdy = 1'b0;
            check_eq("rst_bus", 32'(ob), 32'(7'b1111000));
            check_eq("rst_za", 32'(za), 32'h0);
            check_eq("rst_zd_out", 32'(zd_out), 32'h0);
            check_eq("rst_rsp", 32'({rsp_err, rsp_rdata}), 32'h0);
        end else begin
            t1   = m_act && (cyc == m_acc + 1);
            low  = m_act && (cyc >= m_acc + 2) && (cyc <= m_t3);
            th   = m_act && (cyc == m_t3 + 1);
            busy = t1 || low || th;
            rdy  = th || !busy;
            eb = {!(low && !m_io), !(low && m_io), !(low && !m_wr), !(low && m_wr),
                  busy && m_wr, rdy, th};
            check_eq("bus", 32'(ob), 32'(eb));
            check_eq("za", 32'(za), 32'(m_last_za));
            if (busy && m_wr) check_eq("zd_out", 32'(zd_out), 32'(m_wd));
            if (th) begin
                check_eq("rsp_rdata", 32'(rsp_rdata), 32'(m_err ? 8'hFF : (m_wr ? 8'h00 : m_rd)));
                check_eq("rsp_err", 32'(rsp_err), 32'(m_err));
            end
        end
        if (!zmreq_n || !ziorq_n) low_cnt++;
        if (rsp_valid) begin
            rsp_cnt++;
            last_rsp_cyc = cyc;
            last_err = rsp_err;
            last_rd  = rsp_rdata;
        end

        zi = 8'($urandom);
        if (zw_rand) zw = ($urandom_range(0, 3) != 0);
        else         zw = !((cyc >= zw_from) && (cyc <= zw_to));
        rst = drv_rst; cmd_valid = drv_valid; cmd_wr = drv_wr; cmd_io = drv_io;
        cmd_addr = drv_addr; cmd_wdata = drv_wd; zd_in = zi; zwait_n = zw;

        acc_flag = drv_valid && !drv_rst && rdy;
`ifdef ZBUS_INITIATOR_ZWAIT_EN
        if (m_act && !drv_rst && (cyc == m_t3 - 1) && !zw) begin
            if (m_extra < int'(TMO)) begin
                m_extra++;
                m_t3++;
            end else begin
                m_err = 1'b1;
            end
        end
`endif
        if (m_act && !drv_rst && (cyc == m_t3)) m_rd = zi;
        if (drv_rst) begin
            m_act = 1'b0;
            m_last_za = '0;
        end else if (acc_flag) begin
            m_act = 1'b1; m_acc = cyc; m_wr = drv_wr; m_io = drv_io;
            m_addr = drv_addr; m_wd = drv_wd; m_err = 1'b0; m_extra = 0;
            m_t3 = cyc + 3 + int'(drv_io ? IO_W : MEM_W);
            m_last_za = drv_addr;
        end
        m_rst_prev = drv_rst;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Present a command and hold it until the model says it was taken
    task automatic send(input bit wr, input bit io, input logic [15:0] a, input logic [7:0] d);
        drv_valid = 1'b1; drv_wr = wr; drv_io = io; drv_addr = a; drv_wd = d;
        acc_flag = 1'b0;
        for (int i = 0; i < 64 && !acc_flag; i++) tick();
        if (!acc_flag) begin
            tests++; fails++;
            $display("FAIL accept_timeout @cyc %0d", cyc);
        end
        drv_valid = 1'b0;
    endtask

    initial begin
        int acc1, n_rsp;
        idle(3);
        drv_rst = 1'b0;
        idle(2);

        // I/O write, one fixed wait
        low_cnt = 0;
        send(1'b1, 1'b1, ZB_PORT_83AB, 8'h30);
        acc1 = m_acc;
        idle(7);
        check_eq("iowr_low_cycles", 32'(low_cnt), 32'd3);
        check_eq("iowr_latency", 32'(last_rsp_cyc - acc1), 32'd5);

        // I/O read
        send(1'b0, 1'b1, ZB_PORT_82AB, 8'h00);
        acc1 = m_acc;
        idle(7);
        check_eq("iord_latency", 32'(last_rsp_cyc - acc1), 32'd5);

        // Memory read, no waits
        low_cnt = 0;
        send(1'b0, 1'b0, 16'h1234, 8'h00);
        acc1 = m_acc;
        idle(6);
        check_eq("memrd_low_cycles", 32'(low_cnt), 32'd2);
        check_eq("memrd_latency", 32'(last_rsp_cyc - acc1), 32'd4);

        // Back-to-back: second command taken in the first one's TH
        send(1'b1, 1'b1, ZB_PORT_80AB, 8'h11);
        send(1'b0, 1'b1, ZB_PORT_7FAB, 8'h00);
        check_eq("b2b_accept_in_th", 32'(m_acc), 32'(last_rsp_cyc));
        idle(7);

        // Reset during TW of an I/O read
        n_rsp = rsp_cnt;
        send(1'b0, 1'b1, ZB_PORT_81AB, 8'h00);
        idle(2);
        drv_rst = 1'b1;
        idle(2);
        drv_rst = 1'b0;
        idle(4);
        check_eq("rst_abort_no_rsp", 32'(rsp_cnt), 32'(n_rsp));

`ifdef ZBUS_INITIATOR_ZWAIT_EN
        // zwait_n low for four samples -> four extra TW
        low_cnt = 0;
        send(1'b0, 1'b1, ZB_PORT_82AB, 8'h00);
        acc1 = m_acc;
        zw_from = acc1 + 3; zw_to = acc1 + 6;
        idle(12);
        check_eq("zwait4_low_cycles", 32'(low_cnt), 32'd7);
        check_eq("zwait4_latency", 32'(last_rsp_cyc - acc1), 32'd9);
        check_eq("zwait4_err", 32'(last_err), 32'd0);

        // zwait_n stuck low -> timeout after TMO extra waits
        zw_from = cyc; zw_to = 1 << 30;
        send(1'b0, 1'b1, ZB_PORT_82AB, 8'h00);
        acc1 = m_acc;
        idle(16);
        check_eq("tmo_latency", 32'(last_rsp_cyc - acc1), 32'(5 + TMO));
        check_eq("tmo_err", 32'(last_err), 32'd1);
        check_eq("tmo_rdata", 32'(last_rd), 32'hFF);
        zw_from = -1; zw_to = -1;
        idle(2);
`endif

        // Randomized traffic, random gaps, random zwait_n
        zw_rand = 1'b1;
        for (int k = 0; k < 200; k++) begin
            idle($urandom_range(0, 2));
            send(1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))),
                 16'($urandom), 8'($urandom));
        end
        zw_rand = 1'b0;
        idle(30);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
